// File: rtl/gpu_pkg.sv
// Shared minigpu definitions: control-unit state codes, opcodes and ALU function codes.
// Imported by the decoder and by anything that sequences or consumes its outputs.
package gpu_pkg;

  typedef enum logic [3:0] {
    CU_IDLE    = 4'd0,
    CU_FETCH   = 4'd1,
    CU_DECODE  = 4'd2,
    CU_REQUEST = 4'd3,
    CU_WAIT    = 4'd4,
    CU_EXECUTE = 4'd5,
    CU_UPDATE  = 4'd6,
    CU_DONE    = 4'd7
  } cu_state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_ADDI  = 4'h8;
  localparam logic [3:0] OP_BEQ   = 4'h9;
  localparam logic [3:0] OP_BNE   = 4'hA;
  localparam logic [3:0] OP_BLT   = 4'hB;
  localparam logic [3:0] OP_CONST = 4'hC;
  localparam logic [3:0] OP_LDR   = 4'hD;
  localparam logic [3:0] OP_STR   = 4'hE;
  localparam logic [3:0] OP_RET   = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_ADDI = 4'd7;
  localparam logic [3:0] ALU_BEQ  = 4'd8;
  localparam logic [3:0] ALU_BNE  = 4'd9;
  localparam logic [3:0] ALU_BLT  = 4'd10;

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rimm;
    logic [7:0] imm;
    logic [3:0] alu_func;
    logic       is_alu;
    logic       is_branch;
    logic       is_const;
    logic       is_load;
    logic       is_store;
    logic       is_nop;
    logic       is_jr;
  } dec_t;

endpackage

// File: rtl/gpu_decoder.sv
// Instruction decoder for one minigpu core: latches fields and class flags on DECODE.
// Outputs hold for the rest of the instruction's lifetime until the next DECODE edge.
module gpu_decoder
  import gpu_pkg::*;
#(
  parameter int PC_ADDR_WIDTH  = 8,
  parameter int INST_MSG_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                cu_state,
  input  logic [INST_MSG_WIDTH-1:0] instr,
  output logic [3:0]                rd,
  output logic [3:0]                rs1,
  output logic [3:0]                rs2,
  output logic [3:0]                rimm,
  output logic [7:0]                imm,
  output logic [3:0]                alu_func,
  output logic                      is_alu,
  output logic                      is_branch,
  output logic                      is_const,
  output logic                      is_load,
  output logic                      is_store,
  output logic                      is_nop,
  output logic                      is_jr
);

  // The field layout below is hard-wired to a 16-bit encoding.
  if (INST_MSG_WIDTH != 16 || PC_ADDR_WIDTH < 1) begin : g_bad_param
    $error("gpu_decoder: only 16-bit instructions and a non-zero PC width are supported");
  end

  logic [3:0] opcode;
  dec_t       dec_next;
  dec_t       dec_q;

  assign opcode = instr[15:12];

  always_comb begin
    dec_next           = '0;
    dec_next.rd        = instr[11:8];
    dec_next.rs1       = instr[7:4];
    dec_next.rs2       = instr[3:0];
    dec_next.rimm      = instr[3:0];
    dec_next.imm       = instr[7:0];
    dec_next.alu_func  = ALU_ADD;

    unique case (opcode)
      OP_NOP: dec_next.is_nop = 1'b1;
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
        dec_next.is_alu   = 1'b1;
        dec_next.alu_func = opcode - 4'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT: begin
        // Branches compare two registers, so the sources move up one nibble.
        dec_next.is_alu    = 1'b1;
        dec_next.is_branch = 1'b1;
        dec_next.alu_func  = opcode - 4'd1;
        dec_next.rd        = 4'd0;
        dec_next.rs1       = instr[11:8];
        dec_next.rs2       = instr[7:4];
      end
      OP_CONST: dec_next.is_const = 1'b1;
      OP_LDR:   dec_next.is_load  = 1'b1;
      OP_STR: begin
        dec_next.is_store = 1'b1;
        dec_next.rd       = 4'd0;
      end
      OP_RET:   dec_next.is_jr    = 1'b1;
      default:  dec_next.is_nop   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q <= '0;
    end else if (cu_state == CU_DECODE) begin
      dec_q <= dec_next;
    end
  end

  assign rd        = dec_q.rd;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rimm      = dec_q.rimm;
  assign imm       = dec_q.imm;
  assign alu_func  = dec_q.alu_func;
  assign is_alu    = dec_q.is_alu;
  assign is_branch = dec_q.is_branch;
  assign is_const  = dec_q.is_const;
  assign is_load   = dec_q.is_load;
  assign is_store  = dec_q.is_store;
  assign is_nop    = dec_q.is_nop;
  assign is_jr     = dec_q.is_jr;

endmodule

// File: tb/tb_gpu_decoder.sv
// Directed bench for gpu_decoder: hand-decoded instructions compared field-by-field.
// Packed layout: {rd, rs1, rs2, rimm, imm, alu_func, alu, branch, const, load, store, nop, jr}.
module tb_gpu_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  cu_state;
  logic [15:0] instr;
  logic [3:0]  rd, rs1, rs2, rimm, alu_func;
  logic [7:0]  imm;
  logic        is_alu, is_branch, is_const, is_load, is_store, is_nop, is_jr;

  int n_cmp = 0;
  int n_bad = 0;

  gpu_decoder #(.PC_ADDR_WIDTH(8), .INST_MSG_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cu_state(cu_state), .instr(instr),
    .rd(rd), .rs1(rs1), .rs2(rs2), .rimm(rimm), .imm(imm), .alu_func(alu_func),
    .is_alu(is_alu), .is_branch(is_branch), .is_const(is_const), .is_load(is_load),
    .is_store(is_store), .is_nop(is_nop), .is_jr(is_jr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] obs();
    return {rd, rs1, rs2, rimm, imm, alu_func,
            is_alu, is_branch, is_const, is_load, is_store, is_nop, is_jr};
  endfunction

  function automatic logic [34:0] pk(logic [3:0] e_rd, logic [3:0] e_rs1, logic [3:0] e_rs2,
                                     logic [3:0] e_rimm, logic [7:0] e_imm,
                                     logic [3:0] e_alu, logic [6:0] e_flags);
    return {e_rd, e_rs1, e_rs2, e_rimm, e_imm, e_alu, e_flags};
  endfunction

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present instr in DECODE at a falling edge; the value is captured on the next rising edge
  // and sampled at the falling edge after it.
  task automatic decode(input logic [15:0] v);
    @(negedge clk);
    cu_state = 4'd2;
    instr    = v;
    @(negedge clk);
  endtask

  typedef struct {
    string       tag;
    logic [15:0] ins;
    logic [34:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [34:0] held;

    vecs.push_back('{"branch_beq", 16'h9123, pk(4'h0, 4'h1, 4'h2, 4'h3, 8'h23, 4'd8,  7'b1100000)});
    vecs.push_back('{"const",      16'hC5A7, pk(4'h5, 4'hA, 4'h7, 4'h7, 8'hA7, 4'd0,  7'b0010000)});
    vecs.push_back('{"ldr",        16'hD730, pk(4'h7, 4'h3, 4'h0, 4'h0, 8'h30, 4'd0,  7'b0001000)});
    vecs.push_back('{"str",        16'hE045, pk(4'h0, 4'h4, 4'h5, 4'h5, 8'h45, 4'd0,  7'b0000100)});
    vecs.push_back('{"nop",        16'h0000, pk(4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 4'd0,  7'b0000010)});
    vecs.push_back('{"ret",        16'hF000, pk(4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 4'd0,  7'b0000001)});
    vecs.push_back('{"xor",        16'h7ABC, pk(4'hA, 4'hB, 4'hC, 4'hC, 8'hBC, 4'd6,  7'b1000000)});
    vecs.push_back('{"blt",        16'hB9F1, pk(4'h0, 4'h9, 4'hF, 4'h1, 8'hF1, 4'd10, 7'b1100000)});
    vecs.push_back('{"bne",        16'hAEDC, pk(4'h0, 4'hE, 4'hD, 4'hC, 8'hDC, 4'd9,  7'b1100000)});
    vecs.push_back('{"div",        16'h4FFF, pk(4'hF, 4'hF, 4'hF, 4'hF, 8'hFF, 4'd3,  7'b1000000)});

    reset    = 1'b0;
    cu_state = 4'd2;
    instr    = 16'h1234;
    #1 check("reset_async", obs(), '0);
    repeat (2) @(negedge clk);
    check("reset_held_decode", obs(), '0);

    reset = 1'b1;
    @(negedge clk);
    check("first_add", obs(), pk(4'h2, 4'h3, 4'h4, 4'h4, 8'h34, 4'd0, 7'b1000000));

    foreach (vecs[i]) begin
      decode(vecs[i].ins);
      check(vecs[i].tag, obs(), vecs[i].exp);
    end

    decode(16'h8213);
    held = pk(4'h2, 4'h1, 4'h3, 4'h3, 8'h13, 4'd7, 7'b1000000);
    check("addi", obs(), held);
    cu_state = 4'd5;
    instr    = 16'hF000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("hold_exec_%0d", c), obs(), held);
    end
    cu_state = 4'd3;
    instr    = 16'hC5A7;
    @(negedge clk);
    check("hold_request", obs(), held);

    decode(16'h3456);
    check("mul", obs(), pk(4'h4, 4'h5, 4'h6, 4'h6, 8'h56, 4'd2, 7'b1000000));
    cu_state = 4'd5;
    #2 reset = 1'b0;
    #1 check("reset_mid_op", obs(), '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_hold", obs(), '0);

    decode(16'h2ABC);
    check("sub_after_reset", obs(), pk(4'hA, 4'hB, 4'hC, 4'hC, 8'hBC, 4'd1, 7'b1000000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
